// File: rtl/simd_fetch_sequencer.sv
// Fetch sequencer: runs a program out of instruction BRAM over AXI4-Lite reads and
// hands each word to the SIMD core, bracketed by the START/STOP GPIO handshake.
module simd_fetch_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       N_INSTR   = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [3:0]        HALT_OP   = 4'hF
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      START_SIGNAL,
  output logic                      STOP_SIGNAL,
  output logic [ADDR_W-1:0]         ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_W-1:0]         RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY,
  output logic [DATA_W-1:0]         INSTR,
  output logic                      INSTR_VALID,
  input  logic                      INSTR_READY,
  output logic [$clog2(N_INSTR):0]  PC,
  output logic                      ERR
);

  localparam int unsigned PC_W = $clog2(N_INSTR) + 1;
  localparam logic [PC_W-1:0] PC_END = PC_W'(N_INSTR);
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic              start_q;
  logic              start_arm;
  logic              start_pulse_c;

  logic              stop_nxt;
  logic [ADDR_W-1:0] araddr_nxt;
  logic              arvalid_nxt;
  logic              rready_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic              instr_valid_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              err_nxt;

  logic [PC_W-1:0]   pc_inc;
  logic              halt_hit;
  logic              last_hit;

  // start_arm blocks a level held high across reset release from looking like an edge
  assign start_pulse_c = START_SIGNAL & ~start_q & start_arm;

  assign pc_inc   = (PC == PC_END) ? PC : PC + PC_W'(1);
  assign halt_hit = (INSTR[DATA_W-1 -: 4] == HALT_OP);
  assign last_hit = (pc_inc == PC_END);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      start_q   <= 1'b0;
      start_arm <= 1'b0;
    end else begin
      start_q   <= START_SIGNAL;
      start_arm <= start_arm | ~START_SIGNAL;
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state       <= S_IDLE;
      STOP_SIGNAL <= 1'b0;
      ARADDR      <= BASE_ADDR;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
      INSTR       <= '0;
      INSTR_VALID <= 1'b0;
      PC          <= '0;
      ERR         <= 1'b0;
    end else begin
      state       <= state_nxt;
      STOP_SIGNAL <= stop_nxt;
      ARADDR      <= araddr_nxt;
      ARVALID     <= arvalid_nxt;
      RREADY      <= rready_nxt;
      INSTR       <= instr_nxt;
      INSTR_VALID <= instr_valid_nxt;
      PC          <= pc_nxt;
      ERR         <= err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    stop_nxt        = STOP_SIGNAL;
    araddr_nxt      = ARADDR;
    arvalid_nxt     = ARVALID;
    rready_nxt      = RREADY;
    instr_nxt       = INSTR;
    instr_valid_nxt = INSTR_VALID;
    pc_nxt          = PC;
    err_nxt         = ERR;

    case (state)
      S_IDLE: begin
        if (start_pulse_c) begin
          state_nxt   = S_ADDR;
          pc_nxt      = '0;
          err_nxt     = 1'b0;
          araddr_nxt  = BASE_ADDR;
          arvalid_nxt = 1'b1;
        end
      end

      S_ADDR: begin
        if (ARREADY) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = S_DATA;
        end
      end

      S_DATA: begin
        if (RVALID) begin
          rready_nxt = 1'b0;
          if (RRESP != RESP_OKAY) begin
            err_nxt   = 1'b1;
            stop_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            instr_nxt       = RDATA;
            instr_valid_nxt = 1'b1;
            state_nxt       = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // HALT is still handed to the core; the run ends once it is accepted
        if (INSTR_READY) begin
          instr_valid_nxt = 1'b0;
          pc_nxt          = pc_inc;
          if (halt_hit || last_hit) begin
            stop_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            araddr_nxt  = BASE_ADDR + ADDR_W'({pc_inc, 2'b00});
            arvalid_nxt = 1'b1;
            state_nxt   = S_ADDR;
          end
        end
      end

      S_DONE: begin
        if (!START_SIGNAL) begin
          stop_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt       = S_IDLE;
        stop_nxt        = 1'b0;
        arvalid_nxt     = 1'b0;
        rready_nxt      = 1'b0;
        instr_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
